// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the length-prefixed UART stream loader.
// Frame sizing is derived here so RTL and users agree on bit counts.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    FIN
  } loader_state_t;

  // cpb=1 yields the number of bits in one frame
  function automatic int frame_cycles(
    input int cpb,
    input int par,
    input int stop
  );
    return (9 + ((par != 0) ? 1 : 0) + stop) * cpb;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start, 8 data LSB first, optional parity, stops.
// A load while last is high chains the next frame with no idle gap.
module uart_tx_frame
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       idle,
  output logic       last
);

  localparam int NB = frame_cycles(1, PARITY, STOP_BITS);
  localparam int BW = $clog2(NB);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam parity_t PAR = parity_t'(PARITY);

  logic          active;
  logic [NB-1:0] shreg;
  logic [NB-1:0] frame;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] baud_cnt;
  logic          bit_end;

  always_comb begin
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = data;
    if (PAR != PAR_NONE)
      frame[9] = (^data) ^ (PAR == PAR_ODD);
  end

  assign bit_end = baud_cnt == CW'(CLKS_PER_BIT - 1);
  assign last    = active && bit_end
                && (bit_cnt == BW'(NB - 1));
  assign idle    = !active;
  // active clears asynchronously, so reset drives the line high at once
  assign txd     = active ? shreg[0] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (load && (idle || last)) begin
      active   <= 1'b1;
      shreg    <= frame;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (last) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
          shreg   <= {1'b1, shreg[NB-1:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_stream_loader_tx.sv
// Sends a little-endian length header then that many bytes from a FIFO.
// Payload may be pre-loaded while idle; leftovers stay for the next run.
module uart_stream_loader_tx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int LEN_BYTES    = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*LEN_BYTES-1:0] length,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   txd,
  output logic                   busy,
  output logic                   done,
  output logic [8*LEN_BYTES-1:0] sent_count
);

  localparam int LW = 8 * LEN_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;

  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW])
                 && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  loader_state_t state, state_n;
  logic [LW-1:0] len_q, len_n, cnt_n, cnt_inc;
  logic [2:0]    hdr_idx, hdr_n;
  logic          ser_load, ser_idle, ser_last;
  logic [7:0]    ser_data;

  uart_tx_frame #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY       (PARITY),
    .STOP_BITS    (STOP_BITS)
  ) u_frame (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .data (ser_data),
    .txd  (txd),
    .idle (ser_idle),
    .last (ser_last)
  );

  assign cnt_inc = sent_count + LW'(1);
  assign busy    = (state == HDR) || (state == PAY);
  assign done    = state == FIN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      sent_count <= '0;
      hdr_idx    <= '0;
    end else begin
      state      <= state_n;
      len_q      <= len_n;
      sent_count <= cnt_n;
      hdr_idx    <= hdr_n;
    end
  end

  always_comb begin
    state_n  = state;
    len_n    = len_q;
    cnt_n    = sent_count;
    hdr_n    = hdr_idx;
    ser_load = 1'b0;
    ser_data = mem[rd_ptr[AW-1:0]];
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          len_n    = length;
          cnt_n    = '0;
          hdr_n    = 3'd1;
          ser_load = 1'b1;
          ser_data = length[7:0];
          state_n  = HDR;
        end
      end
      HDR: begin
        if (ser_last) begin
          if (hdr_idx != 3'(LEN_BYTES)) begin
            ser_load = 1'b1;
            ser_data = 8'(len_q >> {hdr_idx, 3'b000});
            hdr_n    = hdr_idx + 3'd1;
          end else if (len_q == '0) begin
            state_n = FIN;
          end else begin
            state_n  = PAY;
            ser_load = !empty;
            pop      = !empty;
          end
        end
      end
      PAY: begin
        if (ser_last) begin
          cnt_n = cnt_inc;
          if (cnt_inc == len_q) begin
            state_n = FIN;
          end else begin
            ser_load = !empty;
            pop      = !empty;
          end
        end else if (ser_idle) begin
          ser_load = !empty;
          pop      = !empty;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_stream_loader_tx.sv
// Scoreboarded bench: expected frames are queued by stimulus and
// popped by per-DUT line monitors that decode txd.
module tb_uart_stream_loader_tx;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start0 = 1'b0, dv0 = 1'b0;
  logic [31:0] len0 = '0;
  logic [7:0]  din0 = '0;
  logic        rdy0, txd0, busy0, done0;
  logic [31:0] sent0;

  logic        startp = 1'b0, dvp = 1'b0;
  logic [31:0] lenp = '0;
  logic [7:0]  dinp = '0;
  logic        rdy1, txd1, busy1, done1;
  logic        rdy2, txd2, busy2, done2;
  logic [31:0] sent1, sent2;

  logic txd_v [3];
  logic done_v [3];
  exp_t exp_q [3][$];
  int   st_q [3][$];
  int   cyc = 0, n_chk = 0, n_fail = 0;

  assign txd_v[0]  = txd0;
  assign txd_v[1]  = txd1;
  assign txd_v[2]  = txd2;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign done_v[2] = done2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_stream_loader_tx dut0 (
    .clk(clk), .rst(rst), .start(start0), .length(len0),
    .in_data(din0), .in_valid(dv0), .in_ready(rdy0),
    .txd(txd0), .busy(busy0), .done(done0), .sent_count(sent0)
  );

  uart_stream_loader_tx #(.PARITY(2)) dut_even (
    .clk(clk), .rst(rst), .start(startp), .length(lenp),
    .in_data(dinp), .in_valid(dvp), .in_ready(rdy1),
    .txd(txd1), .busy(busy1), .done(done1), .sent_count(sent1)
  );

  uart_stream_loader_tx #(.PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .start(startp), .length(lenp),
    .in_data(dinp), .in_valid(dvp), .in_ready(rdy2),
    .txd(txd2), .busy(busy2), .done(done2), .sent_count(sent2)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic expect_b(input int k, input logic [7:0] d,
                          input logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    exp_q[k].push_back(e);
  endtask

  // Decodes frames at mid-bit (CLKS_PER_BIT=5); aborts on reset
  task automatic monitor(input int k, input int nb);
    logic [15:0] fr;
    int   t0;
    bit   ab, ok;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || txd_v[k] !== 1'b0) continue;
      t0 = cyc;
      ab = 0;
      fr = '1;
      for (int b = 0; b < nb && !ab; b++) begin
        for (int c = 0; c < ((b == 0) ? 2 : 5); c++) begin
          @(negedge clk);
          if (rst) ab = 1;
        end
        fr[b] = txd_v[k];
      end
      for (int c = 0; c < 2 && !ab; c++) begin
        @(negedge clk);
        if (rst) ab = 1;
      end
      if (ab) continue;
      st_q[k].push_back(t0);
      n_chk++;
      if (exp_q[k].size() == 0) begin
        n_fail++;
        $display("FAIL unexpected frame dut%0d: got %0h, expected none",
                 k, fr[8:1]);
        continue;
      end
      e  = exp_q[k].pop_front();
      ok = (fr[0] == 1'b0) && (fr[nb-1] == 1'b1) && (fr[8:1] == e.d)
        && ((nb == 10) || (fr[9] == e.p));
      if (!ok) begin
        n_fail++;
        $display("FAIL frame dut%0d: got d=%0h p=%0b s=%0b, expected d=%0h p=%0b",
                 k, fr[8:1], fr[9], fr[nb-1], e.d, e.p);
      end
    end
  endtask

  initial begin
    fork
      monitor(0, 10);
      monitor(1, 11);
      monitor(2, 11);
    join_none
  end

  task automatic push0(input logic [7:0] b, output logic acc);
    @(negedge clk);
    din0 = b;
    dv0  = 1'b1;
    acc  = rdy0;
    @(posedge clk);
    #1 dv0 = 1'b0;
  endtask

  task automatic go0(input logic [31:0] l, output int ts);
    @(negedge clk);
    start0 = 1'b1;
    len0   = l;
    @(posedge clk);
    #1 start0 = 1'b0;
    ts = cyc;
  endtask

  task automatic wait_done(input int k, input int lim, output int t);
    int n = 0;
    t = -1;
    @(negedge clk);
    while (!done_v[k] && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (done_v[k]) t = cyc;
    else chk("done timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int   ts, td, nacc, bad;
    logic acc;
    logic [7:0] b8;

    repeat (3) @(negedge clk);
    chk("reset txd", txd0, 1);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset sent_count", sent0, 0);
    chk("reset in_ready", rdy0, 1);
    rst = 1'b0;

    // header 04 00 00 00 then 15 00 40 00
    push0(8'h15, acc); push0(8'h00, acc);
    push0(8'h40, acc); push0(8'h00, acc);
    expect_b(0, 8'h04, 0); expect_b(0, 8'h00, 0);
    expect_b(0, 8'h00, 0); expect_b(0, 8'h00, 0);
    expect_b(0, 8'h15, 0); expect_b(0, 8'h00, 0);
    expect_b(0, 8'h40, 0); expect_b(0, 8'h00, 0);
    go0(32'd4, ts);
    wait_done(0, 600, td);
    chk("t1 busy at done", busy0, 0);
    chk("t1 sent_count", sent0, 4);
    chk("t1 frames", st_q[0].size(), 8);
    if (st_q[0].size() == 8) begin
      chk("t1 start latency", st_q[0][0], ts);
      chk("t1 done timing", td - st_q[0][0], 400);
      for (int i = 0; i < 7; i++)
        chk("t1 frame gap", st_q[0][i+1] - st_q[0][i], 50);
    end
    @(negedge clk);
    chk("t1 done pulse width", done0, 0);
    chk("t1 scoreboard drained", exp_q[0].size(), 0);

    // parity: byte 0x15 has three ones
    @(negedge clk);
    dinp = 8'h15;
    dvp  = 1'b1;
    @(posedge clk);
    #1 dvp = 1'b0;
    expect_b(1, 8'h01, 1); expect_b(2, 8'h01, 0);
    for (int i = 0; i < 3; i++) begin
      expect_b(1, 8'h00, 0);
      expect_b(2, 8'h00, 1);
    end
    expect_b(1, 8'h15, 1); expect_b(2, 8'h15, 0);
    @(negedge clk);
    startp = 1'b1;
    lenp   = 32'd1;
    @(posedge clk);
    #1 startp = 1'b0;
    wait_done(1, 600, td);
    chk("par done both", done2, 1);
    chk("par sent_count", sent1, 1);
    chk("par frames", st_q[1].size() + st_q[2].size(), 10);
    if (st_q[1].size() == 5 && st_q[2].size() == 5) begin
      chk("even frame len", st_q[1][1] - st_q[1][0], 55);
      chk("odd frame len", st_q[2][1] - st_q[2][0], 55);
      chk("par done timing", td - st_q[1][0], 275);
    end
    @(negedge clk);
    chk("par scoreboard drained", exp_q[1].size() + exp_q[2].size(), 0);

    // length 0: header only, pre-loaded byte kept
    st_q[0].delete();
    push0(8'hA5, acc);
    for (int i = 0; i < 4; i++) expect_b(0, 8'h00, 0);
    go0(32'd0, ts);
    wait_done(0, 400, td);
    chk("len0 done timing", td - ts, 200);
    chk("len0 sent_count", sent0, 0);
    chk("len0 scoreboard drained", exp_q[0].size(), 0);

    // length 3 with one byte queued: underrun then refill
    expect_b(0, 8'h03, 0);
    for (int i = 0; i < 3; i++) expect_b(0, 8'h00, 0);
    expect_b(0, 8'hA5, 0); expect_b(0, 8'h3C, 0); expect_b(0, 8'hC3, 0);
    go0(32'd3, ts);
    bad = 0;
    while (sent0 != 1 && bad < 600) begin
      @(negedge clk);
      bad++;
    end
    chk("underrun first payload", sent0, 1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txd0 !== 1'b1) bad++;
    end
    chk("underrun txd high", bad, 0);
    chk("underrun busy", busy0, 1);
    push0(8'h3C, acc);
    push0(8'hC3, acc);
    wait_done(0, 400, td);
    chk("underrun sent_count", sent0, 3);
    chk("underrun scoreboard drained", exp_q[0].size(), 0);

    // fill FIFO to 16, 17th refused; stray start ignored
    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      b8 = 8'(i + 1);
      push0(b8, acc);
      if (acc) nacc++;
    end
    chk("fifo accepted 16", nacc, 16);
    chk("fifo full in_ready", rdy0, 0);
    push0(8'hEE, acc);
    chk("fifo 17th refused", acc, 0);
    expect_b(0, 8'h10, 0);
    for (int i = 0; i < 3; i++) expect_b(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      b8 = 8'(i + 1);
      expect_b(0, b8, 0);
    end
    st_q[0].delete();
    go0(32'd16, ts);
    repeat (300) @(negedge clk);
    go0(32'd2, td);
    wait_done(0, 1500, td);
    chk("full sent_count", sent0, 16);
    repeat (100) @(negedge clk);
    chk("full frame count", st_q[0].size(), 20);
    chk("full scoreboard drained", exp_q[0].size(), 0);

    // reset during 3rd data bit of first payload frame (0x11)
    push0(8'h11, acc); push0(8'h22, acc); push0(8'h33, acc);
    expect_b(0, 8'h03, 0);
    for (int i = 0; i < 3; i++) expect_b(0, 8'h00, 0);
    go0(32'd3, ts);
    while (cyc < ts + 217) @(negedge clk);
    chk("pre-reset data bit", txd0, 0);
    rst = 1'b1;
    #1;
    chk("async reset txd", txd0, 1);
    chk("async reset busy", busy0, 0);
    chk("async reset in_ready", rdy0, 1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    expect_b(0, 8'h01, 0);
    for (int i = 0; i < 3; i++) expect_b(0, 8'h00, 0);
    go0(32'd1, ts);
    repeat (260) @(negedge clk);
    chk("post-reset fifo empty busy", busy0, 1);
    chk("post-reset fifo empty sent", sent0, 0);
    chk("post-reset fifo empty txd", txd0, 1);
    expect_b(0, 8'h5A, 0);
    push0(8'h5A, acc);
    wait_done(0, 200, td);
    chk("post-reset sent_count", sent0, 1);
    chk("post-reset scoreboard drained", exp_q[0].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
